// File: rtl/xflag_skid_stage.sv
// rtl/xflag_skid_stage.sv - 2-entry valid/ready skid stage with per-word unknown flag and flagged-word counter
module xflag_skid_stage #(
    parameter int WIDTH  = 128,
    parameter int CNT_W  = 8,
    parameter bit POISON = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_unknown,
    output logic [CNT_W-1:0] xcount,
    input  logic             xcount_clr,
    output logic             ctrl_err
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t             state_q;
    occ_t             state_d;
    logic [WIDTH-1:0] mem_q [2];
    logic [1:0]       flag_q;
    logic             head_q;
    logic             tail_q;
    logic [CNT_W-1:0] xcount_q;
    logic             ctrl_err_q;

    logic             in_valid_ok;
    logic             out_ready_ok;
    logic             push;
    logic             pop;
    logic             ctrl_x;

    // An unknown handshake bit never counts as asserted, so occupancy stays known.
    assign in_valid_ok  = !$isunknown(in_valid) && in_valid;
    assign out_ready_ok = !$isunknown(out_ready) && out_ready;
    assign ctrl_x       = $isunknown(in_valid) || $isunknown(out_ready);

    // Ready/valid come purely from registered occupancy: no in->out or out->in paths.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid_ok && in_ready;
    assign pop       = out_ready_ok && out_valid;

    assign xcount   = xcount_q;
    assign ctrl_err = ctrl_err_q;

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy next-state: simultaneous push and pop in ONE keeps one entry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (push) state_d = ONE;
            end
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (!push && pop) state_d = EMPTY;
            end
            FULL: begin
                if (pop) state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Entry storage and pointers; the unknown flag is computed once, at capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            flag_q   <= 2'b00;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
        end else begin
            if (push) begin
                mem_q[tail_q]  <= in_data;
                flag_q[tail_q] <= $isunknown(in_data);
                tail_q         <= ~tail_q;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
        end
    end

    // Head presentation: flagged words are replaced by all-X or all-zero.
    always_comb begin
        out_data    = '0;
        out_unknown = 1'b0;
        if (out_valid) begin
            out_unknown = flag_q[head_q];
            if (!flag_q[head_q]) begin
                out_data = mem_q[head_q];
            end else if (POISON) begin
                out_data = {WIDTH{1'bx}};
            end
        end
    end

    // Saturating count of flagged pops; clear wins over a same-edge increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xcount_q <= '0;
        end else if (xcount_clr) begin
            xcount_q <= '0;
        end else if (pop && flag_q[head_q] && (xcount_q != {CNT_W{1'b1}})) begin
            xcount_q <= xcount_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Sticky flag for unknown handshake controls, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_err_q <= 1'b0;
        end else if (ctrl_x) begin
            ctrl_err_q <= 1'b1;
        end
    end

endmodule
